// File: rtl/stack_memory_stage.sv
// rtl/stack_memory_stage.sv - data memory, stack pointer and push/pop sequencer for the memory stage
module stack_memory_stage #(
    parameter int ADDR_W   = 10,
    parameter int SP_RESET = (1 << ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic [1:0]        stack_kind,
    input  logic [15:0]       address,
    input  logic [15:0]       write_data,
    input  logic [31:0]       pc_in,
    input  logic [2:0]        ccr_in,
    output logic [15:0]       read_data,
    output logic              read_valid,
    output logic [31:0]       pc_out,
    output logic              pc_valid,
    output logic [2:0]        conditions_from_memory_pop,
    output logic              flags_valid,
    output logic              stall,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stack_fault
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_LO,
        PUSH_FLAGS,
        POP_LO,
        POP_HI
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic                fault_q;
    logic                int_q;
    logic [31:0]         pc_push_q;
    logic [2:0]          ccr_push_q;
    logic [15:0]         lo_q;
    logic [15:0]         read_data_q;
    logic                read_valid_q;
    logic [31:0]         pc_out_q;
    logic                pc_valid_q;
    logic [2:0]          flags_q;
    logic                flags_valid_q;

    logic [15:0]         mem [0:DEPTH-1];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [15:0]         mem_wd;

    logic [ADDR_W-1:0]   sp_inc, sp_dec, addr_w;
    logic [15:0]         pop_word, rd_word;
    logic                accept, do_pop, do_push, do_write, do_read;
    logic                kind_pc, kind_int;
    logic                push_step, pop_step, wrap;
    logic                unused_addr_hi;

    assign unused_addr_hi = &{1'b0, address[15:ADDR_W]};

    assign addr_w   = address[ADDR_W-1:0];
    assign sp_inc   = sp_q + 1'b1;
    assign sp_dec   = sp_q - 1'b1;
    assign pop_word = mem[sp_inc];
    assign rd_word  = mem[addr_w];

    // Priority pop > push > write > read when several op bits arrive together.
    assign accept   = req_valid && (state_q == IDLE);
    assign do_pop   = accept && mem_pop;
    assign do_push  = accept && !mem_pop && mem_push;
    assign do_write = accept && !mem_pop && !mem_push && mem_write;
    assign do_read  = accept && !mem_pop && !mem_push && !mem_write && mem_read;

    assign kind_pc  = (stack_kind == 2'b01);
    assign kind_int = (stack_kind == 2'b10);

    assign push_step = do_push || (state_q == PUSH_LO) || (state_q == PUSH_FLAGS);
    assign pop_step  = do_pop  || (state_q == POP_LO)  || (state_q == POP_HI);
    assign wrap      = (push_step && (sp_q == '0)) || (pop_step && (sp_q == '1));

    always_comb begin
        sp_d = sp_q;
        if (push_step)
            sp_d = sp_dec;
        else if (pop_step)
            sp_d = sp_inc;
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = sp_q;
        mem_wd = 16'h0000;
        case (state_q)
            IDLE: begin
                if (do_push) begin
                    mem_we = 1'b1;
                    mem_wd = (kind_pc || kind_int) ? pc_in[31:16] : write_data;
                end else if (do_write) begin
                    mem_we = 1'b1;
                    mem_wa = addr_w;
                    mem_wd = write_data;
                end
            end
            PUSH_LO: begin
                mem_we = 1'b1;
                mem_wd = pc_push_q[15:0];
            end
            PUSH_FLAGS: begin
                mem_we = 1'b1;
                mem_wd = {13'b0, ccr_push_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sp_q          <= SP_RESET[ADDR_W-1:0];
            fault_q       <= 1'b0;
            int_q         <= 1'b0;
            pc_push_q     <= '0;
            ccr_push_q    <= '0;
            lo_q          <= '0;
            read_data_q   <= '0;
            read_valid_q  <= 1'b0;
            pc_out_q      <= '0;
            pc_valid_q    <= 1'b0;
            flags_q       <= '0;
            flags_valid_q <= 1'b0;
        end else begin
            read_valid_q  <= 1'b0;
            pc_valid_q    <= 1'b0;
            flags_valid_q <= 1'b0;
            sp_q          <= sp_d;
            if (wrap)
                fault_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (do_pop) begin
                        if (kind_pc) begin
                            lo_q    <= pop_word;
                            state_q <= POP_HI;
                        end else if (kind_int) begin
                            flags_q       <= pop_word[2:0];
                            flags_valid_q <= 1'b1;
                            state_q       <= POP_LO;
                        end else begin
                            read_data_q  <= pop_word;
                            read_valid_q <= 1'b1;
                        end
                    end else if (do_push) begin
                        pc_push_q  <= pc_in;
                        ccr_push_q <= ccr_in;
                        int_q      <= kind_int;
                        if (kind_pc || kind_int)
                            state_q <= PUSH_LO;
                    end else if (do_read) begin
                        read_data_q  <= rd_word;
                        read_valid_q <= 1'b1;
                    end
                end
                PUSH_LO:    state_q <= int_q ? PUSH_FLAGS : IDLE;
                PUSH_FLAGS: state_q <= IDLE;
                POP_LO: begin
                    lo_q    <= pop_word;
                    state_q <= POP_HI;
                end
                POP_HI: begin
                    pc_out_q   <= {pop_word, lo_q};
                    pc_valid_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall                      = (state_q != IDLE);
    assign read_data                  = read_data_q;
    assign read_valid                 = read_valid_q;
    assign pc_out                     = pc_out_q;
    assign pc_valid                   = pc_valid_q;
    assign conditions_from_memory_pop = flags_q;
    assign flags_valid                = flags_valid_q;
    assign sp_out                     = sp_q;
    assign stack_fault                = fault_q;

endmodule

// File: tb/tb_stack_memory_stage.sv
// tb/tb_stack_memory_stage.sv - directed self-checking bench for stack_memory_stage
module tb_stack_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, mem_read, mem_write, mem_push, mem_pop;
    logic [1:0]  stack_kind;
    logic [15:0] address, write_data;
    logic [31:0] pc_in;
    logic [2:0]  ccr_in;
    logic [15:0] read_data;
    logic        read_valid;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic [2:0]  conditions_from_memory_pop;
    logic        flags_valid;
    logic        stall;
    logic [9:0]  sp_out;
    logic        stack_fault;

    int total = 0;
    int bad   = 0;

    stack_memory_stage #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
        .stack_kind(stack_kind), .address(address), .write_data(write_data),
        .pc_in(pc_in), .ccr_in(ccr_in),
        .read_data(read_data), .read_valid(read_valid),
        .pc_out(pc_out), .pc_valid(pc_valid),
        .conditions_from_memory_pop(conditions_from_memory_pop), .flags_valid(flags_valid),
        .stall(stall), .sp_out(sp_out), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        stack_kind = 2'b00; address = 16'h0; write_data = 16'h0; pc_in = 32'h0; ccr_in = 3'b0;
    endtask

    // op = {pop, push, write, read}; returns 1ns after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] kind, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [31:0] pc, input logic [2:0] ccr);
        req_valid = 1; {mem_pop, mem_push, mem_write, mem_read} = op;
        stack_kind = kind; address = addr; write_data = wd; pc_in = pc; ccr_in = ccr;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        repeat (3) tick();
        chk("rst_sp", sp_out, 32'd1023);
        chk("rst_stall", stall, 0);
        chk("rst_fault", stack_fault, 0);
        chk("rst_outs", {read_valid, pc_valid, flags_valid, read_data, pc_out, conditions_from_memory_pop}, 0);
        reset = 1;
        tick();

        // write then read
        issue(4'b0010, 2'b00, 16'd5, 16'hBEEF, 0, 0);
        chk("wr_no_rv", read_valid, 0);
        issue(4'b0010, 2'b00, 16'd7, 16'h0042, 0, 0);
        issue(4'b0001, 2'b00, 16'd5, 0, 0, 0);
        chk("rd_valid", read_valid, 1);
        chk("rd_data", read_data, 16'hBEEF);
        chk("rd_sp", sp_out, 32'd1023);
        tick();
        chk("rd_pulse", read_valid, 0);
        chk("rd_hold", read_data, 16'hBEEF);

        // data push/pop
        issue(4'b0100, 2'b00, 0, 16'h1234, 0, 0);
        chk("push1_sp", sp_out, 32'd1022);
        issue(4'b0100, 2'b11, 0, 16'h5678, 0, 0);
        chk("push2_sp", sp_out, 32'd1021);
        issue(4'b1000, 2'b00, 0, 0, 0, 0);
        chk("pop1_rv", read_valid, 1);
        chk("pop1_data", read_data, 16'h5678);
        chk("pop1_sp", sp_out, 32'd1022);
        issue(4'b1000, 2'b00, 0, 0, 0, 0);
        chk("pop2_data", read_data, 16'h1234);
        chk("pop2_sp", sp_out, 32'd1023);

        // CALL / RET
        issue(4'b0100, 2'b01, 0, 0, 32'h0001_0020, 0);
        chk("call_stall1", stall, 1);
        chk("call_sp1", sp_out, 32'd1022);
        tick();
        chk("call_stall2", stall, 0);
        chk("call_sp2", sp_out, 32'd1021);
        chk("call_mem_hi", dut.mem[1023], 16'h0001);
        chk("call_mem_lo", dut.mem[1022], 16'h0020);
        issue(4'b1000, 2'b01, 0, 0, 0, 0);
        chk("ret_stall1", stall, 1);
        chk("ret_pv_early", pc_valid, 0);
        tick();
        chk("ret_stall2", stall, 0);
        chk("ret_pv", pc_valid, 1);
        chk("ret_pc", pc_out, 32'h0001_0020);
        chk("ret_sp", sp_out, 32'd1023);
        tick();
        chk("ret_pv_pulse", pc_valid, 0);
        chk("ret_pc_hold", pc_out, 32'h0001_0020);

        // INT / RTI
        issue(4'b0100, 2'b10, 0, 0, 32'hABCD_1234, 3'b101);
        chk("int_stall1", stall, 1);
        tick();
        chk("int_stall2", stall, 1);
        tick();
        chk("int_stall3", stall, 0);
        chk("int_sp", sp_out, 32'd1020);
        chk("int_mem_flags", dut.mem[1021], 16'h0005);
        issue(4'b1000, 2'b10, 0, 0, 0, 0);
        chk("rti_fv", flags_valid, 1);
        chk("rti_flags", conditions_from_memory_pop, 3'b101);
        chk("rti_pv0", pc_valid, 0);
        tick();
        chk("rti_fv_pulse", flags_valid, 0);
        chk("rti_pv1", pc_valid, 0);
        chk("rti_stall", stall, 1);
        tick();
        chk("rti_pv2", pc_valid, 1);
        chk("rti_pc", pc_out, 32'hABCD_1234);
        chk("rti_sp", sp_out, 32'd1023);
        chk("rti_flags_hold", conditions_from_memory_pop, 3'b101);

        // push wins over read
        issue(4'b0101, 2'b00, 16'd5, 16'h7777, 0, 0);
        chk("prio_rv", read_valid, 0);
        chk("prio_sp", sp_out, 32'd1022);
        issue(4'b1000, 2'b00, 0, 0, 0, 0);
        chk("prio_pop", read_data, 16'h7777);

        // request during stall is ignored
        issue(4'b0100, 2'b01, 0, 0, 32'h1111_2222, 0);
        issue(4'b0110, 2'b00, 16'd7, 16'hDEAD, 0, 0);
        chk("ign_sp", sp_out, 32'd1021);
        chk("ign_stall", stall, 0);
        issue(4'b0001, 2'b00, 16'd7, 0, 0, 0);
        chk("ign_mem", read_data, 16'h0042);
        issue(4'b1000, 2'b01, 0, 0, 0, 0);
        tick();
        chk("ign_ret_pc", pc_out, 32'h1111_2222);
        chk("ign_ret_sp", sp_out, 32'd1023);

        // reset during INT PUSH_LO
        issue(4'b0100, 2'b10, 0, 0, 32'hCAFE_F00D, 3'b011);
        chk("mid_stall", stall, 1);
        reset = 0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_sp", sp_out, 32'd1023);
        chk("mid_rst_outs", {pc_valid, read_valid, flags_valid, pc_out}, 0);
        tick();
        tick();
        chk("mid_rst_pv", pc_valid, 0);
        reset = 1;
        tick();
        chk("mid_post_stall", stall, 0);

        // SP wrap
        issue(4'b1000, 2'b00, 0, 0, 0, 0);
        chk("wrap_pop_sp", sp_out, 0);
        chk("wrap_pop_fault", stack_fault, 1);
        tick();
        chk("fault_sticky", stack_fault, 1);
        issue(4'b0100, 2'b00, 0, 16'h3333, 0, 0);
        chk("wrap_push_sp", sp_out, 32'd1023);
        chk("wrap_push_fault", stack_fault, 1);
        reset = 0;
        #1;
        chk("fault_clear", stack_fault, 0);
        reset = 1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
